pwm_peripheral: RTL and testbench

- Consumes the five 8-bit control registers produced by the SPI register-write peripheral: output enables, PWM-mode enables and duty cycle.
- Drives 16 chip outputs. Each output is forced low, forced high, or driven by a shared 8-bit PWM waveform.
- The PWM frequency comes from a clock prescaler: about 3 kHz at a 10 MHz clk with default parameters.
- Duty-cycle changes are double-buffered so that a period is never cut short.

---
 rtl/pwm_peripheral.sv | 79 +++++++
 tb/tb_pwm_peripheral.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// Sixteen-channel output driver: each pin is forced low, forced high, or follows
// one shared 8-bit PWM waveform whose duty is latched at every period boundary.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PERIOD  = 256;
  localparam int unsigned STEP_W  = $clog2(PERIOD);
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned CH_W    = 16;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0]  DUTY_FULL  = {DUTY_W{1'b1}};

  logic [PRESC_W-1:0] presc_cnt;
  logic [STEP_W-1:0]  step_cnt;
  logic [DUTY_W-1:0]  duty_shadow;

  logic               tick;
  logic               bnd;
  logic               sig;
  logic [DUTY_W-1:0]  eff_duty;
  logic [CH_W-1:0]    en_out;
  logic [CH_W-1:0]    en_pwm;
  logic [CH_W-1:0]    out_next;

  // Boundary cycle uses the incoming duty directly so a same-cycle write is honoured.
  always_comb begin
    tick     = 1'b0;
    bnd      = 1'b0;
    sig      = 1'b0;
    eff_duty = duty_shadow;
    en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    tick     = (presc_cnt == PRESC_LAST);
    bnd      = (presc_cnt == '0) && (step_cnt == '0);
    if (bnd) begin
      eff_duty = pwm_duty_cycle;
    end
    sig      = (eff_duty == DUTY_FULL) || (STEP_W'(step_cnt) < eff_duty);
    out_next = en_out & (~en_pwm | {CH_W{sig}});
  end

  // Prescaler, step counter, duty shadow and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt    <= '0;
      step_cnt     <= '0;
      duty_shadow  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      if (tick) begin
        presc_cnt <= '0;
        step_cnt  <= step_cnt + STEP_W'(1);
      end else begin
        presc_cnt <= presc_cnt + PRESC_W'(1);
      end
      if (bnd) begin
        duty_shadow <= pwm_duty_cycle;
      end
      out          <= out_next;
      period_start <= bnd;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a cycle-position model checks every output cycle,
// directed scenarios pin high-time counts and period spacing with literal values.
module tb_pwm_peripheral;

  localparam int P      = 13;
  localparam int PERLEN = 256 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] en_out = '0;
  logic [15:0] en_pwm = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (en_out[7:0]),
    .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0 (en_pwm[7:0]),
    .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the period since the last reset, duty latched at position 0.
  int          m_pos = 0;
  int          m_duty = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_out = '0;
  logic        m_ps = 1'b0;

  always @(posedge clk) begin
    int  step;
    bit  s;
    if (rst) begin
      m_pos   = 0;
      m_duty  = 0;
      m_out   = '0;
      m_ps    = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_pos == 0) m_duty = int'(duty);
      step  = m_pos / P;
      s     = (m_duty == 255) || (step < m_duty);
      m_out = en_out & (~en_pwm | {16{s}});
      m_ps  = (m_pos == 0);
      m_pos = (m_pos + 1) % PERLEN;
    end
    #1;
    if (m_valid) begin
      check("out_model", 32'(out), 32'(m_out));
      check("ps_model", 32'(period_start), 32'(m_ps));
    end
  end

  task automatic step1();
    @(posedge clk);
    #2;
  endtask

  // Advance until period_start is seen (at least one step), bounded.
  task automatic wait_next_ps(input string name);
    bit found = 1'b0;
    for (int i = 0; i < PERLEN + 10; i++) begin
      step1();
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: period_start timeout, got 0 expected 1", name);
    end
  endtask

  // Count out[0] high cycles over n periods, starting on a period_start cycle.
  task automatic measure(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n * PERLEN; i++) begin
      hi += int'(out[0]);
      step1();
    end
  endtask

  initial begin
    int hi;
    int pulses;
    int last;
    int bad;

    // 1: reset, all zero
    step1(); step1(); step1();
    check("reset_out", 32'(out), 32'h0);
    check("reset_ps", 32'(period_start), 32'h0);
    rst = 1'b0;
    step1();
    check("first_ps", 32'(period_start), 32'h1);
    pulses = 0; last = 0; bad = 0;
    for (int c = 1; c <= 10000; c++) begin
      step1();
      if (out != 16'h0) bad++;
      if (period_start) begin
        pulses++;
        if (c - last != PERLEN) bad++;
        last = c;
      end
    end
    check("idle_pulses", 32'(pulses), 32'd3);
    check("idle_bad", 32'(bad), 32'd0);

    // 2: static high on all pins
    en_out = 16'hFFFF; en_pwm = 16'h0000; duty = 8'h80;
    step1();
    check("static_first", 32'(out), 32'hFFFF);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step1();
      if (out != 16'hFFFF) bad++;
    end
    check("static_hold", 32'(bad), 32'd0);

    // 3: 50% PWM on channel 0
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_next_ps("t3_sync");
    check("t3_rise", 32'(out), 32'h1);
    measure(1, hi);
    check("t3_high", 32'(hi), 32'd1664);

    // 4: duty boundaries
    duty = 8'h00;
    wait_next_ps("t4_sync0");
    measure(2, hi);
    check("duty00_high", 32'(hi), 32'd0);
    duty = 8'hFF;
    wait_next_ps("t4_syncff");
    measure(2, hi);
    check("dutyff_high", 32'(hi), 32'(2 * PERLEN));
    duty = 8'h01;
    wait_next_ps("t4_sync01");
    measure(1, hi);
    check("duty01_high", 32'(hi), 32'd13);

    // 5: mid-period duty change deferred to the next boundary
    duty = 8'h40;
    wait_next_ps("t5_sync");
    hi = 0;
    for (int i = 0; i < PERLEN; i++) begin
      if (i == 100 * P) duty = 8'hC0;
      hi += int'(out[0]);
      step1();
    end
    check("t5_cur", 32'(hi), 32'd832);
    check("t5_ps", 32'(period_start), 32'h1);
    measure(1, hi);
    check("t5_next", 32'(hi), 32'd2496);

    // 6: reset mid-period
    en_out = 16'hFF00; en_pwm = 16'hF000; duty = 8'h80;
    wait_next_ps("t6_sync");
    for (int i = 0; i < 500; i++) step1();
    rst = 1'b1;
    step1();
    check("t6_rst_out", 32'(out), 32'h0);
    check("t6_rst_ps", 32'(period_start), 32'h0);
    rst = 1'b0;
    step1();
    check("t6_ps", 32'(period_start), 32'h1);
    check("t6_out_hi", 32'(out), 32'hFF00);
    for (int i = 0; i < 1700; i++) step1();
    check("t6_out_lo", 32'(out), 32'h0F00);

    // Random traffic, occasional resets; the model checks each cycle.
    for (int k = 0; k < 15; k++) begin
      en_out = 16'($urandom);
      en_pwm = 16'($urandom);
      case ($urandom_range(0, 3))
        0: duty = 8'h00;
        1: duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) begin
        rst = 1'b1;
        step1();
        rst = 1'b0;
      end
      for (int i = 0; i < int'($urandom_range(1, 1500)); i++) step1();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
